// File: rtl/fptd_ctrl_pkg.sv
// Shared control types and default sizes for the forward-recursion sequencers.
package fptd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } sched_state_e;

    localparam int DEF_LW        = 10;
    localparam int DEF_CW        = 8;
    localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/razor_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value it will
// take at the next edge so callers can make decisions on the updated count.
module razor_sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = '0;
        else if (inc && (count != {W{1'b1}}))
            count_nxt = count + 1'b1;
    end

    // Counter register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/alpha_razor_sched.sv
// Sequencer for the Razor-protected alpha recursion: steps through one frame,
// stalls on each Razor error, aborts after too many consecutive stalls, and
// reports a per-frame error count and alarm.
module alpha_razor_sched
    import fptd_ctrl_pkg::*;
#(
    parameter int LW        = DEF_LW,
    parameter int CW        = DEF_CW,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    input  logic [CW-1:0] err_thresh,
    input  logic          err_in,
    output logic          init_alpha,
    output logic          step_en,
    output logic [LW-1:0] step_idx,
    output logic          busy,
    output logic          done,
    output logic          abort,
    output logic [CW-1:0] err_count,
    output logic          err_alarm
);

    // Retry counter must be able to hold MAX_RETRY+1 so overflow is visible.
    localparam int RW = $clog2(MAX_RETRY + 2);

    sched_state_e  state;
    logic [LW-1:0] k_q;
    logic [CW-1:0] thresh_q;
    logic [CW-1:0] err_nxt;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          accept;
    logic          run_err;
    logic          last_step;
    logic          retry_ovf;

    // Decode of the current cycle's events; step_en follows err_in directly.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        run_err   = (state == S_RUN) && err_in;
        step_en   = (state == S_RUN) && !err_in;
        last_step = step_en && (step_idx == (k_q - LW'(1)));
        retry_ovf = run_err && (retry_nxt > RW'(MAX_RETRY));
    end

    razor_sat_counter #(.W(CW)) u_err_cnt (
        .Clock     (Clock),
        .nReset    (nReset),
        .clr       (accept),
        .inc       (run_err),
        .count     (err_count),
        .count_nxt (err_nxt)
    );

    // Consecutive-stall count on the current step; a clean step resets it.
    razor_sat_counter #(.W(RW)) u_retry_cnt (
        .Clock     (Clock),
        .nReset    (nReset),
        .clr       (accept | step_en),
        .inc       (run_err),
        .count     (retry_cnt),
        .count_nxt (retry_nxt)
    );

    // Frame FSM with registered control outputs. The alarm is taken from the
    // counter's next value so an error on the final cycle is included.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            k_q        <= '0;
            thresh_q   <= '0;
            step_idx   <= '0;
            init_alpha <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            err_alarm  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q        <= frame_len;
                        thresh_q   <= err_thresh;
                        step_idx   <= '0;
                        abort      <= 1'b0;
                        err_alarm  <= 1'b0;
                        init_alpha <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    init_alpha <= 1'b0;
                    if (k_q == '0) begin
                        done      <= 1'b1;
                        err_alarm <= (err_nxt >= thresh_q);
                        state     <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step_en)
                        step_idx <= step_idx + LW'(1);
                    if (last_step || retry_ovf) begin
                        done      <= 1'b1;
                        abort     <= retry_ovf;
                        err_alarm <= (err_nxt >= thresh_q);
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_razor_sched.sv
// Scoreboard bench for alpha_razor_sched (CW=2 so saturation is reachable).
module tb_alpha_razor_sched;

    localparam int LW = 10;
    localparam int CW = 2;
    localparam int MR = 3;

    typedef struct {
        int steps;
        int idx;
        int abrt;
        int cnt;
        int alarm;
        int lat;
    } exp_t;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [CW-1:0] err_thresh = '0;
    logic          err_in = 1'b0;
    logic          init_alpha, step_en, busy, done, abort, err_alarm;
    logic [LW-1:0] step_idx;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    alpha_razor_sched #(.LW(LW), .CW(CW), .MAX_RETRY(MR)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .start      (start),
        .frame_len  (frame_len),
        .err_thresh (err_thresh),
        .err_in     (err_in),
        .init_alpha (init_alpha),
        .step_en    (step_en),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .err_count  (err_count),
        .err_alarm  (err_alarm)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts steps since init_alpha, compares on each done pulse.
    int cyc = 0, init_cyc = 0, steps = 0;
    always @(negedge Clock) begin
        cyc++;
        if (init_alpha) begin
            init_cyc = cyc;
            steps = 0;
        end
        if (step_en) steps++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("steps", steps, e.steps);
                chk("step_idx", int'(step_idx), e.idx);
                chk("abort", int'(abort), e.abrt);
                chk("err_count", int'(err_count), e.cnt);
                chk("err_alarm", int'(err_alarm), e.alarm);
                chk("latency", cyc - init_cyc, e.lat);
            end
        end
    end

    // One frame: mask bit j drives err_in in RUN cycle j; glitch>=0 pulses
    // start (with another length) in that RUN cycle.
    task automatic run_frame(input int k, input int th, input logic [63:0] mask,
                             input int glitch, input exp_t e);
        int j;
        sb.push_back(e);
        @(posedge Clock); #1;
        start = 1'b1; frame_len = LW'(k); err_thresh = CW'(th);
        @(posedge Clock); #1;
        start = 1'b0; frame_len = LW'(7);
        j = 0;
        while (j < 200) begin
            @(posedge Clock); #1;
            start = 1'b0;
            if (done) break;
            err_in = mask[j];
            if (j == glitch) start = 1'b1;
            j++;
        end
        err_in = 1'b0;
        if (j >= 200) chk("frame_timeout", j, 0);
        @(posedge Clock); #1;
        chk("done_pulse_1cyc", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("cnt_hold", int'(err_count), e.cnt);
        chk("alarm_hold", int'(err_alarm), e.alarm);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_outputs", int'({init_alpha, step_en, step_idx, busy, done, abort, err_count, err_alarm}), 0);
        @(negedge Clock); nReset = 1'b1;

        // Reset in the middle of RUN at step 4 of 8.
        @(posedge Clock); #1;
        start = 1'b1; frame_len = LW'(8); err_thresh = CW'(1);
        @(posedge Clock); #1;
        start = 1'b0;
        n = 0;
        while (step_idx != LW'(4) && n < 50) begin
            @(posedge Clock); #1; n++;
        end
        chk("reach_step4", int'(step_idx), 4);
        nReset = 1'b0;
        #2;
        chk("midrun_rst_outputs", int'({init_alpha, step_en, step_idx, busy, done, abort, err_count, err_alarm}), 0);
        @(negedge Clock); nReset = 1'b1;

        // K=5 clean, thresh 1: no alarm.
        run_frame(5, 1, 64'h0, -1, '{steps:5, idx:5, abrt:0, cnt:0, alarm:0, lat:6});
        // K=5, single error on step 2.
        run_frame(5, 1, 64'h4, -1, '{steps:5, idx:5, abrt:0, cnt:1, alarm:1, lat:7});
        // K=4, err held 4 cycles on step 1: abort; count saturates at 3.
        run_frame(4, 3, 64'h1E, -1, '{steps:1, idx:1, abrt:1, cnt:3, alarm:1, lat:6});
        // K=0: INIT then DONE; thresh 0 makes 0>=0 raise alarm.
        run_frame(0, 0, 64'h0, -1, '{steps:0, idx:0, abrt:0, cnt:0, alarm:1, lat:1});
        // Error on the last step delays completion by one cycle.
        run_frame(3, 2, 64'h4, -1, '{steps:3, idx:3, abrt:0, cnt:1, alarm:0, lat:5});
        // Exactly MAX_RETRY consecutive stalls are recovered.
        run_frame(3, 3, 64'hE, -1, '{steps:3, idx:3, abrt:0, cnt:3, alarm:1, lat:7});
        // K=20, 5 isolated errors: count saturates; start while busy ignored.
        run_frame(20, 2, 64'h0000_0000_0010_4224, 3,
                  '{steps:20, idx:20, abrt:0, cnt:3, alarm:1, lat:26});

        repeat (3) @(posedge Clock);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alpha_razor_sched.md
# alpha_razor_sched

Sequencer for the Razor-protected alpha forward-recursion stage. Walks the recursion through one frame of trellis steps, stalls one cycle whenever the stage flags a Razor timing error so the corrected state metrics settle before the next step, and aborts after repeated consecutive errors. Keeps a per-frame error count and alarm for the supply-voltage controller. Sits between the frame controller and the alpha pipeline, next to the branch-metric fetch.

## Interface
- LW, 10, width of frame length and step index
- CW, 8, width of error counter and threshold
- MAX_RETRY, 3, consecutive stalled cycles tolerated on one step before abort (≥1)

- Clock  in  1  clock, rising edge
- nReset  in  1  reset, asynchronous, active-low
- start  in  1  begin frame; honoured only in IDLE
- frame_len  in  LW  trellis steps K; sampled on accepted start
- err_thresh  in  CW  alarm threshold; sampled on accepted start
- err_in  in  1  Razor error flag from alpha stage, same cycle as its corrected outputs
- init_alpha  out  1  selects initial alpha metrics into the stage
- step_en  out  1  advance alpha pipeline register and branch-metric fetch
- step_idx  out  LW  index of step currently computed
- busy  out  1  high from INIT through DONE
- done  out  1  one-cycle end-of-frame pulse
- abort  out  1  valid with done; frame ended by retry overflow
- err_count  out  CW  saturating Razor errors in current/last frame
- err_alarm  out  1  err_count ≥ err_thresh, registered, updated at done

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE: all control outputs 0. start=1 → latch frame_len and err_thresh, clear err_count, retry count, step_idx, abort → INIT.
- INIT (1 cycle): init_alpha=1, step_en=0. Go to DONE if latched K=0 (zero steps, abort=0), else RUN.
- RUN: step_en = !err_in (combinational). With step_en=1: step_idx increments at the edge; retry count clears; if step_idx==K-1 → DONE. With err_in=1: step_idx holds, err_count increments (saturating at 2^CW-1), retry count increments; when retry count would exceed MAX_RETRY → DONE with abort=1.
- DONE (1 cycle): done=1; err_alarm updated from err_count ≥ err_thresh; → IDLE. err_count, err_alarm, abort hold until next accepted start.
- err_in ignored outside RUN. start ignored when busy.
- Reset at any time: immediate return to IDLE; all outputs 0, counters 0.

## Timing
- Reset values: init_alpha, step_en, step_idx, busy, done, abort, err_count, err_alarm all 0.
- start at edge n → INIT in cycle n+1 → first step_en in cycle n+2.
- Error-free frame: exactly K step_en cycles; done asserts the cycle after the last step (start-to-done K+2 cycles).
- Each isolated error adds exactly one cycle.
- Retry bound: MAX_RETRY stalled cycles on the same step are recovered; the (MAX_RETRY+1)th consecutive err_in → DONE next cycle.
- err_in and last step cannot coincide: err_in on step K-1 stalls it; completion waits for a clean cycle.

## Structure
- Shared package fptd_ctrl_pkg: state enum type, default LW/CW/MAX_RETRY constants.
- One sub-module: razor_sat_counter (parameterised width, clear, increment, saturate), used for err_count and retry count.
- All state in always_ff with async active-low reset.

## Test plan
- Reset mid-RUN (K=8, step_idx=4) → next cycle all outputs 0, state IDLE; new start runs full frame.
- K=5, no errors → step_en high 5 cycles, step_idx 0..4, done at start+7, err_count=0, err_alarm=0.
- K=5, err_in single cycle during step 2, err_thresh=1 → 6 step cycles total, step_idx holds at 2 one cycle, err_count=1, err_alarm=1 at done.
- K=4, MAX_RETRY=3, err_in held 4 cycles at step 1 → done with abort=1, err_count=4, step_idx=1.
- K=0 → INIT then DONE, no step_en, done at start+2, abort=0.
- CW=2, 5 scattered errors in K=20 → err_count saturates at 3; start pulsed while busy has no effect.
